alu_share_arbiter: RTL and testbench

- Shares one `alu_top` instance between two requesters: port 0 is the integer pipe, port 1 is the address-generation unit.
- Arbitrates round-robin and registers the winning operands.
- Returns each result, tagged with requester ID and transaction tag, on a single back-pressured response channel.
- Sits between the decode/issue stage and the register-file writeback arbiter.

---
 rtl/alu_pkg.sv | 43 ++++
 rtl/alu_share_arbiter_rr_arbiter2.sv | 21 ++
 rtl/alu_top.sv | 59 +++++
 rtl/alu_share_arbiter.sv | 150 +++++++++++++++
 tb/tb_alu_share_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU share arbiter slice.
//   OPC_R / OPC_I   : supported instruction opcodes
//   F7_ALT          : funct7 value selecting SUB / SRA / SRAI
//   alu_f3_e        : ALU funct3 operation encodings
//   alu_req_t       : packed request (operands, control fields, tag)
//   opcode_supported: true for R-type and I-type opcodes
package alu_pkg;

   localparam logic [6:0] OPC_R  = 7'b0110011;
   localparam logic [6:0] OPC_I  = 7'b0010011;
   localparam logic [6:0] F7_ALT = 7'b0100000;

   typedef enum logic [2:0] {
      ADD  = 3'd0,
      SLL  = 3'd1,
      SLT  = 3'd2,
      SLTU = 3'd3,
      XOR  = 3'd4,
      SRL  = 3'd5,
      OR   = 3'd6,
      AND  = 3'd7
   } alu_f3_e;

   // Request field widths; the arbiter's WIDTH / TAG_W defaults track these.
   localparam int unsigned REQ_WIDTH = 32;
   localparam int unsigned REQ_TAG_W = 4;

   typedef struct packed {
      logic [REQ_WIDTH-1:0] rs1;
      logic [REQ_WIDTH-1:0] rs2;
      logic [2:0]           funct3;
      logic [6:0]           funct7;
      logic [6:0]           opcode;
      logic [11:0]          imm;
      logic [4:0]           shamt;
      logic [REQ_TAG_W-1:0] tag;
   } alu_req_t;

   function automatic logic opcode_supported(input logic [6:0] opc);
      return (opc == OPC_R) || (opc == OPC_I);
   endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter2.sv
// rr_arbiter2: combinational two-way round-robin grant.
//   req  : request valids, bit N = port N
//   prio : port favoured when both request
//   en   : grants allowed this cycle
//   gnt  : one-hot grant, never set for a non-requesting port
module rr_arbiter2 (
   input  logic [1:0] req,
   input  logic       prio,
   input  logic       en,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = '0;
      if (en) begin
         if (req == 2'b11) gnt = prio ? 2'b10 : 2'b01;
         else              gnt = req;
      end
   end

endmodule

// File: rtl/alu_top.sv
// alu_top: combinational RV32I-style integer ALU.
//   clk, rst            : present for instance compatibility; no state inside
//   rs1, rs2            : operands (rs2 used by R-type only)
//   funct3, funct7      : operation select; funct7 == 0100000 picks SUB / SRA
//   opcode              : R-type or I-type; anything else sets err
//   imm, shamt          : I-type immediate (sign-extended) and shift amount
//   result              : ALU result, 0 when err
//   err                 : opcode unsupported
module alu_top
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] rs1,
   input  logic [WIDTH-1:0] rs2,
   input  logic [2:0]       funct3,
   input  logic [6:0]       funct7,
   input  logic [6:0]       opcode,
   input  logic [11:0]      imm,
   input  logic [4:0]       shamt,
   output logic [WIDTH-1:0] result,
   output logic             err
);

   logic             unused_clk_rst;
   logic             is_r;
   logic             is_i;
   logic             alt;
   logic [WIDTH-1:0] op_b;
   logic [4:0]       sh;

   assign unused_clk_rst = clk ^ rst;

   always_comb begin
      is_r   = (opcode == OPC_R);
      is_i   = (opcode == OPC_I);
      err    = !(is_r || is_i);
      alt    = (funct7 == F7_ALT);
      op_b   = is_r ? rs2 : {{(WIDTH-12){imm[11]}}, imm};
      sh     = is_r ? rs2[4:0] : shamt;
      result = '0;
      if (!err) begin
         case (alu_f3_e'(funct3))
            ADD:     result = (is_r && alt) ? (rs1 - op_b) : (rs1 + op_b);
            SLL:     result = rs1 << sh;
            SLT:     result = {{(WIDTH-1){1'b0}}, ($signed(rs1) < $signed(op_b))};
            SLTU:    result = {{(WIDTH-1){1'b0}}, (rs1 < op_b)};
            XOR:     result = rs1 ^ op_b;
            SRL:     result = alt ? $unsigned($signed(rs1) >>> sh) : (rs1 >> sh);
            OR:      result = rs1 | op_b;
            AND:     result = rs1 & op_b;
            default: result = '0;
         endcase
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one alu_top between the integer pipe (port 0)
// and the address-generation unit (port 1).
//   clk, rst (async, active-low)
//   pN_valid / pN_ready         : request handshake per port
//   pN_rs1 .. pN_shamt, pN_tag  : request operands, control and tag
//   rsp_valid / rsp_ready       : back-pressured response handshake
//   rsp_id, rsp_tag, rsp_data, rsp_err : response payload
// Two stages: issue register (IS) feeds the ALU combinationally, result
// register (RS) drives the response channel.
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = REQ_WIDTH,
   parameter int unsigned TAG_W = REQ_TAG_W
) (
   input  logic             clk,
   input  logic             rst,

   input  logic             p0_valid,
   output logic             p0_ready,
   input  logic [WIDTH-1:0] p0_rs1,
   input  logic [WIDTH-1:0] p0_rs2,
   input  logic [2:0]       p0_funct3,
   input  logic [6:0]       p0_funct7,
   input  logic [6:0]       p0_opcode,
   input  logic [11:0]      p0_imm,
   input  logic [4:0]       p0_shamt,
   input  logic [TAG_W-1:0] p0_tag,

   input  logic             p1_valid,
   output logic             p1_ready,
   input  logic [WIDTH-1:0] p1_rs1,
   input  logic [WIDTH-1:0] p1_rs2,
   input  logic [2:0]       p1_funct3,
   input  logic [6:0]       p1_funct7,
   input  logic [6:0]       p1_opcode,
   input  logic [11:0]      p1_imm,
   input  logic [4:0]       p1_shamt,
   input  logic [TAG_W-1:0] p1_tag,

   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [TAG_W-1:0] rsp_tag,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_err
);

   alu_req_t         p0_req;
   alu_req_t         p1_req;
   alu_req_t         is_req;
   logic             is_valid;
   logic             is_id;
   logic             prio;
   logic             rs_load;
   logic             is_free;
   logic [1:0]       gnt;
   logic [WIDTH-1:0] alu_result;
   logic             alu_err;

   always_comb begin
      p0_req        = '0;
      p0_req.rs1    = p0_rs1;
      p0_req.rs2    = p0_rs2;
      p0_req.funct3 = p0_funct3;
      p0_req.funct7 = p0_funct7;
      p0_req.opcode = p0_opcode;
      p0_req.imm    = p0_imm;
      p0_req.shamt  = p0_shamt;
      p0_req.tag    = p0_tag;

      p1_req        = '0;
      p1_req.rs1    = p1_rs1;
      p1_req.rs2    = p1_rs2;
      p1_req.funct3 = p1_funct3;
      p1_req.funct7 = p1_funct7;
      p1_req.opcode = p1_opcode;
      p1_req.imm    = p1_imm;
      p1_req.shamt  = p1_shamt;
      p1_req.tag    = p1_tag;
   end

   assign rs_load = is_valid && (!rsp_valid || rsp_ready);
   assign is_free = !is_valid || rs_load;

   // Gating with rst keeps both readies low throughout reset even though
   // the cleared IS would otherwise look free.
   rr_arbiter2 u_arb (
      .req  ({p1_valid, p0_valid}),
      .prio (prio),
      .en   (is_free && rst),
      .gnt  (gnt)
   );

   assign p0_ready = gnt[0];
   assign p1_ready = gnt[1];

   alu_top #(
      .WIDTH (WIDTH)
   ) u_alu (
      .clk    (clk),
      .rst    (1'b0),
      .rs1    (is_req.rs1),
      .rs2    (is_req.rs2),
      .funct3 (is_req.funct3),
      .funct7 (is_req.funct7),
      .opcode (is_req.opcode),
      .imm    (is_req.imm),
      .shamt  (is_req.shamt),
      .result (alu_result),
      .err    (alu_err)
   );

   // Issue stage and round-robin pointer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         is_valid <= 1'b0;
         is_id    <= 1'b0;
         is_req   <= '0;
         prio     <= 1'b0;
      end else if (|gnt) begin
         is_valid <= 1'b1;
         is_id    <= gnt[1];
         is_req   <= gnt[1] ? p1_req : p0_req;
         prio     <= gnt[0];
      end else if (rs_load) begin
         is_valid <= 1'b0;
      end
   end

   // Result stage.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_tag   <= '0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
      end else if (rs_load) begin
         rsp_valid <= 1'b1;
         rsp_id    <= is_id;
         rsp_tag   <= is_req.tag;
         rsp_data  <= alu_result;
         rsp_err   <= alu_err;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: randomized bench with a behavioural model of the
// two-slot arbiter pipeline and an ISA-level ALU reference, plus directed
// cases with hand-computed expectations.
module tb_alu_share_arbiter;

   localparam int W  = 32;
   localparam int TW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          p0_valid = 1'b0, p1_valid = 1'b0;
   logic          p0_ready, p1_ready;
   logic [W-1:0]  p0_rs1 = '0, p0_rs2 = '0, p1_rs1 = '0, p1_rs2 = '0;
   logic [2:0]    p0_funct3 = '0, p1_funct3 = '0;
   logic [6:0]    p0_funct7 = '0, p1_funct7 = '0;
   logic [6:0]    p0_opcode = '0, p1_opcode = '0;
   logic [11:0]   p0_imm = '0, p1_imm = '0;
   logic [4:0]    p0_shamt = '0, p1_shamt = '0;
   logic [TW-1:0] p0_tag = '0, p1_tag = '0;
   logic          rsp_valid, rsp_id, rsp_err;
   logic          rsp_ready = 1'b0;
   logic [TW-1:0] rsp_tag;
   logic [W-1:0]  rsp_data;

   always #5 clk = ~clk;

   alu_share_arbiter #(.WIDTH(W), .TAG_W(TW)) dut (
      .clk(clk), .rst(rst),
      .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_rs1(p0_rs1), .p0_rs2(p0_rs2),
      .p0_funct3(p0_funct3), .p0_funct7(p0_funct7), .p0_opcode(p0_opcode),
      .p0_imm(p0_imm), .p0_shamt(p0_shamt), .p0_tag(p0_tag),
      .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_rs1(p1_rs1), .p1_rs2(p1_rs2),
      .p1_funct3(p1_funct3), .p1_funct7(p1_funct7), .p1_opcode(p1_opcode),
      .p1_imm(p1_imm), .p1_shamt(p1_shamt), .p1_tag(p1_tag),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_tag(rsp_tag), .rsp_data(rsp_data), .rsp_err(rsp_err)
   );

   typedef struct {
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] a;
      logic [31:0] b;
      logic [11:0] imm;
      logic [4:0]  sh;
      logic [3:0]  tag;
   } req_s;

   typedef struct {
      logic        id;
      logic [3:0]  tag;
      logic [31:0] data;
      logic        err;
   } rsp_s;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ISA-level reference for the supported RV32I register/immediate ops.
   function automatic logic [31:0] ref_alu(input req_s r);
      logic [31:0]        b;
      logic signed [31:0] sa;
      int                 s;
      logic               alt;
      logic               rt;
      rt = (r.op == 7'h33);
      if (!rt && r.op != 7'h13) return 32'd0;
      b   = rt ? r.b : {{20{r.imm[11]}}, r.imm};
      s   = rt ? int'(r.b[4:0]) : int'(r.sh);
      alt = (r.f7 == 7'h20);
      sa  = r.a;
      case (r.f3)
         3'd0:    return (rt && alt) ? r.a - b : r.a + b;
         3'd1:    return r.a << s;
         3'd2:    return ($signed(r.a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd3:    return (r.a < b) ? 32'd1 : 32'd0;
         3'd4:    return r.a ^ b;
         3'd5:    return alt ? 32'(sa >>> s) : r.a >> s;
         3'd6:    return r.a | b;
         default: return r.a & b;
      endcase
   endfunction

   function automatic req_s mkreq(input logic [6:0] op, input logic [2:0] f3,
                                  input logic [6:0] f7, input logic [31:0] a,
                                  input logic [31:0] b, input logic [11:0] imm,
                                  input logic [4:0] sh, input logic [3:0] tag);
      req_s r;
      r.op = op; r.f3 = f3; r.f7 = f7; r.a = a; r.b = b;
      r.imm = imm; r.sh = sh; r.tag = tag;
      return r;
   endfunction

   function automatic rsp_s exp_of(input logic id, input req_s r);
      rsp_s e;
      e.id   = id;
      e.tag  = r.tag;
      e.data = ref_alu(r);
      e.err  = !(r.op == 7'h33 || r.op == 7'h13);
      return e;
   endfunction

   function automatic req_s port_req(input int p);
      if (p == 0)
         return mkreq(p0_opcode, p0_funct3, p0_funct7, p0_rs1, p0_rs2, p0_imm, p0_shamt, p0_tag);
      return mkreq(p1_opcode, p1_funct3, p1_funct7, p1_rs1, p1_rs2, p1_imm, p1_shamt, p1_tag);
   endfunction

   // Model: one slot waiting for the ALU, one slot presented as response.
   logic m_is_full, m_rs_full, m_prio;
   rsp_s m_is, m_rs;
   logic mg0, mg1, cg0, cg1;

   function automatic void calc_grant(output logic g0, output logic g1);
      logic free;
      free = !(m_is_full && m_rs_full) || rsp_ready;
      g0 = free && p0_valid && (!p1_valid || !m_prio);
      g1 = free && p1_valid && (!p0_valid ||  m_prio);
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_is_full = 1'b0;
         m_rs_full = 1'b0;
         m_prio    = 1'b0;
      end else begin
         calc_grant(mg0, mg1);
         if (m_is_full && (!m_rs_full || rsp_ready)) begin
            m_rs      = m_is;
            m_rs_full = 1'b1;
            m_is_full = 1'b0;
         end else if (m_rs_full && rsp_ready) begin
            m_rs_full = 1'b0;
         end
         if (mg0 || mg1) begin
            m_is      = exp_of(mg1, port_req(mg1 ? 1 : 0));
            m_is_full = 1'b1;
            m_prio    = mg0;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("reset_ctl", {p0_ready, p1_ready, rsp_valid, rsp_id, rsp_tag, rsp_err}, 0);
         chk("reset_data", rsp_data, 0);
      end else begin
         calc_grant(cg0, cg1);
         chk("ready", {p0_ready, p1_ready}, {cg0, cg1});
         chk("rsp_valid", rsp_valid, m_rs_full);
         if (m_rs_full)
            chk("rsp_payload", {rsp_id, rsp_tag, rsp_err, rsp_data},
                {m_rs.id, m_rs.tag, m_rs.err, m_rs.data});
      end
   end

   // Stimulus helpers. Inputs change 1 time unit after a rising edge.
   logic acc0, acc1;
   int   grant_log[$];

   task automatic gen(output req_s r);
      int k;
      k = $urandom_range(0, 9);
      r.op  = (k < 5) ? 7'h33 : (k < 9) ? 7'h13 : 7'($urandom);
      r.f3  = 3'($urandom);
      r.f7  = ($urandom_range(0, 2) == 0) ? 7'h20 :
              ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'h00;
      r.a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      r.b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      r.imm = 12'($urandom);
      r.sh  = 5'($urandom);
      r.tag = 4'($urandom);
   endtask

   task automatic set_port(input int p, input req_s r);
      if (p == 0) begin
         p0_opcode = r.op; p0_funct3 = r.f3; p0_funct7 = r.f7; p0_rs1 = r.a;
         p0_rs2 = r.b; p0_imm = r.imm; p0_shamt = r.sh; p0_tag = r.tag; p0_valid = 1'b1;
      end else begin
         p1_opcode = r.op; p1_funct3 = r.f3; p1_funct7 = r.f7; p1_rs1 = r.a;
         p1_rs2 = r.b; p1_imm = r.imm; p1_shamt = r.sh; p1_tag = r.tag; p1_valid = 1'b1;
      end
   endtask

   task automatic cycle(input int v0, input int v1, input int rdy, input bit log_g);
      req_s r;
      @(negedge clk);
      acc0 = p0_valid && p0_ready;
      acc1 = p1_valid && p1_ready;
      if (log_g) begin
         if (acc0) grant_log.push_back(0);
         if (acc1) grant_log.push_back(1);
      end
      @(posedge clk); #1;
      if (!p0_valid || acc0) begin
         if ($urandom_range(0, 99) < v0) begin gen(r); set_port(0, r); end
         else p0_valid = 1'b0;
      end
      if (!p1_valid || acc1) begin
         if ($urandom_range(0, 99) < v1) begin gen(r); set_port(1, r); end
         else p1_valid = 1'b0;
      end
      rsp_ready = ($urandom_range(0, 99) < rdy);
   endtask

   task automatic drain();
      p0_valid = 1'b0; p1_valid = 1'b0; rsp_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
   endtask

   // Single request on an idle pipeline with rsp_ready high.
   task automatic send_and_check(input string nm, input int p, input req_s r,
                                 input logic [31:0] exp_data, input logic exp_err);
      bit got, seen;
      int lat;
      rsp_ready = 1'b1;
      set_port(p, r);
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if ((p == 0) ? p0_ready : p1_ready) got = 1;
         @(posedge clk); #1;
      end
      chk({nm, "_accept"}, got, 1);
      if (p == 0) p0_valid = 1'b0; else p1_valid = 1'b0;
      lat = 1; seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (rsp_valid) seen = 1;
         else begin lat++; @(posedge clk); #1; end
      end
      chk({nm, "_seen"}, seen, 1);
      if (seen) begin
         chk({nm, "_latency"}, lat, 2);
         chk({nm, "_data"}, rsp_data, exp_data);
         chk({nm, "_err"}, rsp_err, exp_err);
         chk({nm, "_id"}, rsp_id, p[0]);
         chk({nm, "_tag"}, rsp_tag, r.tag);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      int n;
      repeat (3) @(posedge clk);
      @(negedge clk); #2;
      rst = 1'b1;
      @(posedge clk); #1;

      // Pin the reference model with hand-computed values.
      chk("pin_add",  ref_alu(mkreq(7'h33, 3'd0, 7'h00, 32'd5, 32'd7, 12'd0, 5'd0, 4'd0)), 32'd12);
      chk("pin_sub",  ref_alu(mkreq(7'h33, 3'd0, 7'h20, 32'd5, 32'd7, 12'd0, 5'd0, 4'd0)), 32'hFFFF_FFFE);
      chk("pin_sra",  ref_alu(mkreq(7'h33, 3'd5, 7'h20, 32'h8000_0000, 32'd4, 12'd0, 5'd0, 4'd0)), 32'hF800_0000);
      chk("pin_addi", ref_alu(mkreq(7'h13, 3'd0, 7'h00, 32'd10, 32'd0, 12'hFFF, 5'd0, 4'd0)), 32'd9);
      chk("pin_bad",  ref_alu(mkreq(7'h7F, 3'd0, 7'h00, 32'd10, 32'd3, 12'd0, 5'd0, 4'd0)), 32'd0);

      send_and_check("add",  0, mkreq(7'h33, 3'd0, 7'h00, 32'd5, 32'd7, 12'd0, 5'd0, 4'h3), 32'd12, 1'b0);
      send_and_check("slt",  0, mkreq(7'h33, 3'd2, 7'h00, 32'hFFFF_FFFF, 32'd1, 12'd0, 5'd0, 4'h4), 32'd1, 1'b0);
      send_and_check("sltu", 0, mkreq(7'h33, 3'd3, 7'h00, 32'hFFFF_FFFF, 32'd1, 12'd0, 5'd0, 4'h5), 32'd0, 1'b0);
      send_and_check("slli", 0, mkreq(7'h13, 3'd1, 7'h00, 32'd1, 32'd0, 12'd4, 5'd4, 4'h6), 32'h10, 1'b0);
      send_and_check("illegal", 1, mkreq(7'h7F, 3'd0, 7'h00, 32'd9, 32'd9, 12'd0, 5'd0, 4'hA), 32'd0, 1'b1);

      // Round-robin: last accept was port 1, so port 0 is favoured next.
      grant_log.delete();
      repeat (5) cycle(100, 100, 100, 1);
      chk("rr_count", (grant_log.size() >= 4), 1);
      if (grant_log.size() >= 4)
         chk("rr_order", {grant_log[0][0], grant_log[1][0], grant_log[2][0], grant_log[3][0]}, 4'b0101);
      drain();

      // Back-pressure: one response held, one waiting in issue.
      grant_log.delete();
      repeat (6) cycle(100, 100, 0, 1);
      chk("bp_accepts", grant_log.size(), 2);
      @(negedge clk);
      chk("bp_full", {rsp_valid, p0_valid, p1_valid, p0_ready, p1_ready}, 5'b11100);
      @(posedge clk); #1;
      p0_valid = 1'b0; p1_valid = 1'b0; rsp_ready = 1'b1;
      n = 0;
      repeat (6) begin
         @(negedge clk);
         if (rsp_valid && rsp_ready) n++;
         @(posedge clk); #1;
      end
      chk("bp_drained", n, 2);

      // Randomized traffic in a few load mixes.
      repeat (600) cycle(60, 60, 70, 0);
      repeat (400) cycle(90, 90, 30, 0);
      repeat (400) cycle(30, 80, 95, 0);
      drain();

      // Reset mid-stream with a response pending.
      repeat (3) cycle(100, 100, 0, 0);
      @(negedge clk);
      chk("pre_rst_valid", rsp_valid, 1);
      #2 rst = 1'b0;
      #1;
      chk("rst_async_ctl", {p0_ready, p1_ready, rsp_valid, rsp_id, rsp_tag, rsp_err}, 0);
      chk("rst_async_data", rsp_data, 0);
      p0_valid = 1'b0; p1_valid = 1'b0; rsp_ready = 1'b1;
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      @(posedge clk); #1;
      send_and_check("post_rst_add", 0, mkreq(7'h33, 3'd0, 7'h00, 32'd5, 32'd7, 12'd0, 5'd0, 4'h1), 32'd12, 1'b0);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
